// File: rtl/scan_decoder_pkg.sv
// Shared definitions for scan_decoder: geometry defaults, character codes, the 14-segment
// glyph table and the FSM states. Bit 13 is segment a; bits 5..0 are h,i,j,k,l,m (diagonals/centre).
package scan_decoder_pkg;

    localparam int DIGITS_DEF = 12;
    localparam int SEG_W_DEF  = 14;

    localparam logic [5:0] CODE_DIGIT0 = 6'd0;
    localparam logic [5:0] CODE_A      = 6'd10;
    localparam logic [5:0] CODE_NTILDE = 6'd36;
    localparam logic [5:0] CODE_BLANK  = 6'd37;
    localparam logic [5:0] CODE_UNK    = 6'd63;

    localparam logic [13:0] G_0      = 14'b11111100001001;
    localparam logic [13:0] G_1      = 14'b01100000000000;
    localparam logic [13:0] G_2      = 14'b11011011000000;
    localparam logic [13:0] G_3      = 14'b11110001000000;
    localparam logic [13:0] G_4      = 14'b01100111000000;
    localparam logic [13:0] G_5      = 14'b10110111000000;  // also the S glyph
    localparam logic [13:0] G_6      = 14'b10111111000000;
    localparam logic [13:0] G_7      = 14'b11100000000000;
    localparam logic [13:0] G_8      = 14'b11111111000000;
    localparam logic [13:0] G_9      = 14'b11110111000000;
    localparam logic [13:0] G_A      = 14'b11101111000000;
    localparam logic [13:0] G_B      = 14'b11110001010010;
    localparam logic [13:0] G_C      = 14'b10011100000000;
    localparam logic [13:0] G_D      = 14'b11110000010010;
    localparam logic [13:0] G_E      = 14'b10011110000000;
    localparam logic [13:0] G_F      = 14'b10001110000000;
    localparam logic [13:0] G_G      = 14'b10111101000000;
    localparam logic [13:0] G_H      = 14'b01101111000000;
    localparam logic [13:0] G_I      = 14'b10010000010010;
    localparam logic [13:0] G_J      = 14'b01111000000000;
    localparam logic [13:0] G_K      = 14'b00001110001100;
    localparam logic [13:0] G_L      = 14'b00011100000000;
    localparam logic [13:0] G_M      = 14'b01101100101000;
    localparam logic [13:0] G_N      = 14'b01101100100100;
    localparam logic [13:0] G_O      = 14'b11111100000000;
    localparam logic [13:0] G_P      = 14'b11001111000000;
    localparam logic [13:0] G_Q      = 14'b11111100000100;
    localparam logic [13:0] G_R      = 14'b11001111000100;
    localparam logic [13:0] G_T      = 14'b10000000010010;
    localparam logic [13:0] G_U      = 14'b01111100000000;
    localparam logic [13:0] G_V      = 14'b00001100001001;
    localparam logic [13:0] G_W      = 14'b01101100000101;
    localparam logic [13:0] G_X      = 14'b00000000101101;
    localparam logic [13:0] G_Y      = 14'b00000000101010;
    localparam logic [13:0] G_Z      = 14'b10010000001001;
    localparam logic [13:0] G_NTILDE = 14'b11101100100100;
    localparam logic [13:0] G_BLANK  = 14'b00000000000000;

    typedef enum logic [1:0] {HUNT, CAPTURE, DRAIN} state_t;

endpackage

// File: rtl/seg14_to_code.sv
// Combinational 14-segment pattern to 6-bit character code lookup; unrecognised patterns give CODE_UNK.
module seg14_to_code
    import scan_decoder_pkg::*;
#(
    parameter int SEG_W = SEG_W_DEF
) (
    input  logic [SEG_W-1:0] seg,
    output logic [5:0]       code
);

    always_comb begin
        case (seg)
            G_0:      code = CODE_DIGIT0;
            G_1:      code = CODE_DIGIT0 + 6'd1;
            G_2:      code = CODE_DIGIT0 + 6'd2;
            G_3:      code = CODE_DIGIT0 + 6'd3;
            G_4:      code = CODE_DIGIT0 + 6'd4;
            G_5:      code = CODE_DIGIT0 + 6'd5;  // S shares this glyph and reads as the digit
            G_6:      code = CODE_DIGIT0 + 6'd6;
            G_7:      code = CODE_DIGIT0 + 6'd7;
            G_8:      code = CODE_DIGIT0 + 6'd8;
            G_9:      code = CODE_DIGIT0 + 6'd9;
            G_A:      code = CODE_A;
            G_B:      code = CODE_A + 6'd1;
            G_C:      code = CODE_A + 6'd2;
            G_D:      code = CODE_A + 6'd3;
            G_E:      code = CODE_A + 6'd4;
            G_F:      code = CODE_A + 6'd5;
            G_G:      code = CODE_A + 6'd6;
            G_H:      code = CODE_A + 6'd7;
            G_I:      code = CODE_A + 6'd8;
            G_J:      code = CODE_A + 6'd9;
            G_K:      code = CODE_A + 6'd10;
            G_L:      code = CODE_A + 6'd11;
            G_M:      code = CODE_A + 6'd12;
            G_N:      code = CODE_A + 6'd13;
            G_O:      code = CODE_A + 6'd14;
            G_P:      code = CODE_A + 6'd15;
            G_Q:      code = CODE_A + 6'd16;
            G_R:      code = CODE_A + 6'd17;
            G_T:      code = CODE_A + 6'd19;
            G_U:      code = CODE_A + 6'd20;
            G_V:      code = CODE_A + 6'd21;
            G_W:      code = CODE_A + 6'd22;
            G_X:      code = CODE_A + 6'd23;
            G_Y:      code = CODE_A + 6'd24;
            G_Z:      code = CODE_A + 6'd25;
            G_NTILDE: code = CODE_NTILDE;
            G_BLANK:  code = CODE_BLANK;
            default:  code = CODE_UNK;
        endcase
    end

endmodule

// File: rtl/scan_decoder.sv
// Captures one frame from a multiplexed 14-segment scan and replays it as a valid/ready character stream.
// Optional SCAN_CHANGE_FILTER_EN suppresses draining a frame identical to the last one emitted.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int SEG_W  = SEG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [DIGITS-1:0] sel_in,
    input  logic [SEG_W-1:0]  segm_in,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [5:0]        char_code,
    output logic [3:0]        char_pos,
    output logic              frame_done,
    output logic              err_seq,
    output logic              err_glyph,
    output logic [7:0]        drop_cnt
);

    localparam logic [3:0] LAST_POS = 4'(DIGITS - 1);

    state_t     state_q, state_d;
    logic [3:0] exp_q, exp_d, pos_q, pos_d;
    logic       valid_d, frame_done_d, err_seq_d, err_glyph_d, prev_first_q;
    logic [7:0] drop_d;
    logic [5:0] code_w;
    logic [5:0] frame_q [DIGITS];
    logic       wr_en;
    logic [3:0] wr_pos;
    logic       sel_first, sel_exp, sel_held, frame_match;

    seg14_to_code #(.SEG_W(SEG_W)) u_lut (.seg(segm_in), .code(code_w));

    assign sel_first = (sel_in == DIGITS'(1));
    assign sel_exp   = (sel_in == (DIGITS'(1) << exp_q));
    assign sel_held  = (sel_in == (DIGITS'(1) << (exp_q - 4'd1)));

`ifdef SCAN_CHANGE_FILTER_EN
    logic [5:0] last_q [DIGITS];
    logic       have_last_q;
    logic       enter_drain;

    assign enter_drain = (state_q == CAPTURE) && (state_d == DRAIN);

    // The position being sampled right now is not in frame_q yet, so compare it from the LUT.
    always_comb begin
        frame_match = have_last_q && (code_w == last_q[DIGITS-1]);
        for (int i = 0; i < DIGITS - 1; i++)
            if (frame_q[i] != last_q[i]) frame_match = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) have_last_q <= 1'b0;
        else if (enter_drain) have_last_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (enter_drain)
            for (int i = 0; i < DIGITS; i++)
                last_q[i] <= (i == DIGITS - 1) ? code_w : frame_q[i];
    end
`else
    assign frame_match = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        exp_d        = exp_q;
        pos_d        = pos_q;
        valid_d      = char_valid;
        drop_d       = drop_cnt;
        frame_done_d = 1'b0;
        err_seq_d    = 1'b0;
        wr_en        = 1'b0;
        wr_pos       = exp_q;
        case (state_q)
            HUNT: begin
                if (sample_en && sel_first) begin
                    wr_en   = 1'b1;
                    wr_pos  = 4'd0;
                    exp_d   = 4'd1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_en && sel_exp) begin
                    wr_en = 1'b1;
                    if (exp_q == LAST_POS) begin
                        frame_done_d = 1'b1;
                        exp_d        = 4'd0;
                        if (frame_match) begin
                            state_d = HUNT;
                        end else begin
                            state_d = DRAIN;
                            valid_d = 1'b1;
                            pos_d   = 4'd0;
                        end
                    end else begin
                        exp_d = exp_q + 4'd1;
                    end
                end else if (sample_en && !sel_held) begin
                    err_seq_d = 1'b1;
                    if (sel_first) begin
                        wr_en  = 1'b1;
                        wr_pos = 4'd0;
                        exp_d  = 4'd1;
                    end else begin
                        exp_d   = 4'd0;
                        state_d = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (char_valid && char_ready) begin
                    if (pos_q == LAST_POS) begin
                        valid_d = 1'b0;
                        pos_d   = 4'd0;
                        state_d = HUNT;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
                // A fresh position-0 sample marks the start of a frame we cannot accept.
                if (sample_en && sel_first && !prev_first_q && drop_cnt != 8'hFF)
                    drop_d = drop_cnt + 8'd1;
            end
            default: state_d = HUNT;
        endcase
        err_glyph_d = wr_en && (code_w == CODE_UNK);
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            exp_q        <= 4'd0;
            pos_q        <= 4'd0;
            char_valid   <= 1'b0;
            frame_done   <= 1'b0;
            err_seq      <= 1'b0;
            err_glyph    <= 1'b0;
            drop_cnt     <= 8'd0;
            prev_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            pos_q      <= pos_d;
            char_valid <= valid_d;
            frame_done <= frame_done_d;
            err_seq    <= err_seq_d;
            err_glyph  <= err_glyph_d;
            drop_cnt   <= drop_d;
            if (sample_en) prev_first_q <= sel_first;
        end
    end

    // NOTE: the frame buffer has no reset; it is only read after being fully written by a capture.
    always_ff @(posedge clk) begin
        if (wr_en) frame_q[wr_pos] <= code_w;
    end

    assign char_code = char_valid ? frame_q[pos_q] : 6'd0;
    assign char_pos  = pos_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: expected characters are queued when a frame is scanned
// and popped by a negedge monitor as the DUT hands them over.
module tb_scan_decoder;

    localparam logic [13:0] P_A   = 14'b11101111000000;
    localparam logic [13:0] P_D   = 14'b11110000010010;
    localparam logic [13:0] P_E   = 14'b10011110000000;
    localparam logic [13:0] P_I   = 14'b10010000010010;
    localparam logic [13:0] P_L   = 14'b00011100000000;
    localparam logic [13:0] P_N   = 14'b01101100100100;
    localparam logic [13:0] P_X   = 14'b00000000101101;
    localparam logic [13:0] P_2   = 14'b11011011000000;
    localparam logic [13:0] P_0   = 14'b11111100001001;
    localparam logic [13:0] P_BAD = 14'b11111111111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] sel_in = '0;
    logic [13:0] segm_in = '0;
    logic        char_valid;
    logic        char_ready = 1'b0;
    logic [5:0]  char_code;
    logic [3:0]  char_pos;
    logic        frame_done, err_seq, err_glyph;
    logic [7:0]  drop_cnt;

    scan_decoder dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sel_in(sel_in), .segm_in(segm_in),
        .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code), .char_pos(char_pos),
        .frame_done(frame_done), .err_seq(err_seq), .err_glyph(err_glyph), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] code; logic [3:0] pos; } exp_t;
    exp_t sb [$];

    int n_cmp = 0, n_bad = 0;
    int fd_cnt = 0, es_cnt = 0, eg_cnt = 0, acc_cnt = 0;
    bit toggle_rdy = 1'b0;
    bit stall_prev = 1'b0;
    logic [5:0] hold_code;
    logic [3:0] hold_pos;
    logic [13:0] pat [12];
    logic [5:0]  code_exp [12];

    always @(negedge clk) begin
        exp_t item;
        if (frame_done) fd_cnt++;
        if (err_seq) es_cnt++;
        if (err_glyph) eg_cnt++;
        if (stall_prev && char_valid) begin
            n_cmp++;
            if (char_code !== hold_code || char_pos !== hold_pos) begin
                n_bad++;
                $display("FAIL stall_stable: code=%0d pos=%0d, required code=%0d pos=%0d",
                         char_code, char_pos, hold_code, hold_pos);
            end
        end
        stall_prev = char_valid && !char_ready && !rst;
        hold_code  = char_code;
        hold_pos   = char_pos;
        if (char_valid && char_ready && !rst) begin
            acc_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL char_unexpected: code=%0d pos=%0d, required no character", char_code, char_pos);
            end else begin
                item = sb.pop_front();
                if (char_code !== item.code || char_pos !== item.pos) begin
                    n_bad++;
                    $display("FAIL char_stream: code=%0d pos=%0d, required code=%0d pos=%0d",
                             char_code, char_pos, item.code, item.pos);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) char_ready = ~char_ready;
    endtask

    task automatic do_reset();
        sample_en  = 1'b0;
        sel_in     = '0;
        toggle_rdy = 1'b0;
        char_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
    endtask

    task automatic load_daniel();
        pat      = '{P_D, P_A, P_N, P_I, P_E, P_L, P_2, P_0, P_0, P_0, P_X, P_X};
        code_exp = '{6'd13, 6'd10, 6'd23, 6'd18, 6'd14, 6'd21, 6'd2, 6'd0, 6'd0, 6'd0, 6'd33, 6'd33};
    endtask

    task automatic push_frame();
        exp_t item;
        for (int p = 0; p < 12; p++) begin
            item.code = code_exp[p];
            item.pos  = 4'(p);
            sb.push_back(item);
        end
    endtask

    task automatic scan(input int hold);
        for (int p = 0; p < 12; p++) begin
            for (int h = 0; h < hold; h++) begin
                sample_en = 1'b1;
                sel_in    = 12'b1 << p;
                segm_in   = pat[p];
                tick();
            end
        end
        sample_en = 1'b0;
        sel_in    = '0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || char_valid) && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_bad++;
            $display("FAIL %s_drain_timeout: %0d chars pending, required 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp += 7;
        if (char_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", char_valid); end
        if (char_code !== 6'd0) begin n_bad++; $display("FAIL reset_code: got %0d, required 0", char_code); end
        if (char_pos !== 4'd0) begin n_bad++; $display("FAIL reset_pos: got %0d, required 0", char_pos); end
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        if (err_seq !== 1'b0) begin n_bad++; $display("FAIL reset_err_seq: got %b, required 0", err_seq); end
        if (err_glyph !== 1'b0) begin n_bad++; $display("FAIL reset_err_glyph: got %b, required 0", err_glyph); end
        if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_frame();
        int fd0, acc0, es0, eg0;
        do_reset();
        load_daniel();
        char_ready = 1'b1;
        fd0 = fd_cnt; acc0 = acc_cnt; es0 = es_cnt; eg0 = eg_cnt;
        push_frame();
        scan(1);
        n_cmp += 3;
        if (frame_done !== 1'b1) begin n_bad++; $display("FAIL clean_done_timing: got %b, required 1", frame_done); end
        if (char_valid !== 1'b1) begin n_bad++; $display("FAIL clean_valid_timing: got %b, required 1", char_valid); end
        if (char_pos !== 4'd0) begin n_bad++; $display("FAIL clean_first_pos: got %0d, required 0", char_pos); end
        wait_drain("clean");
        n_cmp += 3;
        if (fd_cnt - fd0 != 1) begin n_bad++; $display("FAIL clean_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
        if (acc_cnt - acc0 != 12) begin n_bad++; $display("FAIL clean_char_count: got %0d, required 12", acc_cnt - acc0); end
        if (es_cnt - es0 + eg_cnt - eg0 != 0) begin n_bad++; $display("FAIL clean_errors: got %0d pulses, required 0", es_cnt - es0 + eg_cnt - eg0); end
    endtask

    task automatic test_held_stall();
        int fd0, acc0, es0;
        do_reset();
        load_daniel();
        fd0 = fd_cnt; acc0 = acc_cnt; es0 = es_cnt;
        push_frame();
        toggle_rdy = 1'b1;
        scan(3);
        wait_drain("held");
        toggle_rdy = 1'b0;
        char_ready = 1'b0;
        n_cmp += 3;
        if (fd_cnt - fd0 != 1) begin n_bad++; $display("FAIL held_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
        if (acc_cnt - acc0 != 12) begin n_bad++; $display("FAIL held_char_count: got %0d, required 12", acc_cnt - acc0); end
        if (es_cnt - es0 != 0) begin n_bad++; $display("FAIL held_err_seq: got %0d pulses, required 0", es_cnt - es0); end
    endtask

    task automatic test_seq_error();
        int order [4];
        int fd0, es0, acc0;
        order = '{0, 1, 2, 4};
        do_reset();
        char_ready = 1'b1;
        fd0 = fd_cnt; es0 = es_cnt; acc0 = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            sample_en = 1'b1;
            sel_in    = 12'b1 << order[k];
            segm_in   = P_0;
            tick();
        end
        sample_en = 1'b0;
        sel_in    = '0;
        n_cmp++;
        if (err_seq !== 1'b1) begin n_bad++; $display("FAIL seq_err_timing: got %b, required 1", err_seq); end
        repeat (4) tick();
        n_cmp += 3;
        if (es_cnt - es0 != 1) begin n_bad++; $display("FAIL seq_err_pulses: got %0d, required 1", es_cnt - es0); end
        if (fd_cnt - fd0 != 0) begin n_bad++; $display("FAIL seq_no_frame: got %0d pulses, required 0", fd_cnt - fd0); end
        if (acc_cnt - acc0 != 0) begin n_bad++; $display("FAIL seq_no_chars: got %0d, required 0", acc_cnt - acc0); end
        load_daniel();
        push_frame();
        scan(1);
        wait_drain("seq_recover");
        n_cmp++;
        if (acc_cnt - acc0 != 12) begin n_bad++; $display("FAIL seq_recover_chars: got %0d, required 12", acc_cnt - acc0); end
    endtask

    task automatic test_glyph_error();
        int eg0, acc0;
        do_reset();
        load_daniel();
        pat[5]      = P_BAD;
        code_exp[5] = 6'd63;
        char_ready  = 1'b1;
        eg0 = eg_cnt; acc0 = acc_cnt;
        push_frame();
        scan(1);
        wait_drain("glyph");
        n_cmp += 2;
        if (eg_cnt - eg0 != 1) begin n_bad++; $display("FAIL glyph_err_pulses: got %0d, required 1", eg_cnt - eg0); end
        if (acc_cnt - acc0 != 12) begin n_bad++; $display("FAIL glyph_char_count: got %0d, required 12", acc_cnt - acc0); end
    endtask

    task automatic test_drop_and_reset();
        int acc0;
        do_reset();
        load_daniel();
        push_frame();
        scan(1);
        for (int p = 0; p < 12; p++) pat[p] = P_0;
        scan(1);
        scan(1);
        n_cmp += 4;
        if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL drop_count: got %0d, required 2", drop_cnt); end
        if (char_valid !== 1'b1) begin n_bad++; $display("FAIL drop_valid_held: got %b, required 1", char_valid); end
        if (char_pos !== 4'd0) begin n_bad++; $display("FAIL drop_pos_held: got %0d, required 0", char_pos); end
        if (char_code !== 6'd13) begin n_bad++; $display("FAIL drop_code_held: got %0d, required 13", char_code); end
        char_ready = 1'b1;
        repeat (3) tick();
        char_ready = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp += 2;
        if (char_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain_valid: got %b, required 0", char_valid); end
        if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_drain_drop: got %0d, required 0", drop_cnt); end
        rst = 1'b0;
        sb.delete();
        acc0 = acc_cnt;
        char_ready = 1'b1;
        repeat (20) tick();
        n_cmp += 2;
        if (acc_cnt - acc0 != 0) begin n_bad++; $display("FAIL rst_abort_chars: got %0d, required 0", acc_cnt - acc0); end
        if (char_valid !== 1'b0) begin n_bad++; $display("FAIL rst_abort_valid: got %b, required 0", char_valid); end
    endtask

    task automatic test_repeat_frame();
        int fd0, acc0, acc_req;
        do_reset();
        char_ready = 1'b1;
        fd0 = fd_cnt; acc0 = acc_cnt;
        load_daniel();
        push_frame();
        scan(1);
        wait_drain("repeat_first");
`ifdef SCAN_CHANGE_FILTER_EN
        scan(1);
        n_cmp++;
        if (char_valid !== 1'b0) begin n_bad++; $display("FAIL repeat_filtered_valid: got %b, required 0", char_valid); end
        acc_req = 24;
`else
        push_frame();
        scan(1);
        acc_req = 36;
`endif
        wait_drain("repeat_second");
        pat[7]      = P_2;
        code_exp[7] = 6'd2;
        push_frame();
        scan(1);
        wait_drain("repeat_changed");
        n_cmp += 2;
        if (fd_cnt - fd0 != 3) begin n_bad++; $display("FAIL repeat_frame_done: got %0d pulses, required 3", fd_cnt - fd0); end
        if (acc_cnt - acc0 != acc_req) begin n_bad++; $display("FAIL repeat_char_count: got %0d, required %0d", acc_cnt - acc0, acc_req); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_held_stall();
        test_seq_error();
        test_glyph_error();
        test_drop_and_reset();
        test_repeat_frame();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL leftover_chars: got %0d, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
